// File: rtl/note_decoder.sv
// rtl/note_decoder.sv - recovers which of 17 synth keys (C4..E5) is sounding on a 1-bit audio line
// Optional duty-cycle qualification of each measured period: define NOTE_DECODER_DUTY_CHECK_EN.
module note_decoder #(
  parameter int CNT_W     = 16,
  parameter int TOL       = 256,
  parameter int STABLE_N  = 3,
  // The ROM holds periods in 10 MHz cycles; a slower hwclk divides them by 2**ROM_SHIFT.
  parameter int ROM_SHIFT = 0
) (
  input  logic             hwclk,
  input  logic             reset,
  input  logic             audio_in,
  output logic             note_valid,
  output logic [4:0]       note_idx,
  output logic [16:0]      note_onehot,
  output logic             note_strobe,
  output logic [CNT_W-1:0] period_out
);
  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]        ONE      = CNT_W'(1);
  localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(TOL);
  localparam logic [CW-1:0]           STABLE_C = CW'(STABLE_N);
  localparam logic [CW-1:0]           CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  function automatic logic [15:0] rom_val(input int i);
    case (i)
      0:  rom_val = 16'd38222;  1: rom_val = 16'd36077;  2: rom_val = 16'd34053;
      3:  rom_val = 16'd32141;  4: rom_val = 16'd30337;  5: rom_val = 16'd28635;
      6:  rom_val = 16'd27027;  7: rom_val = 16'd25510;  8: rom_val = 16'd24079;
      9:  rom_val = 16'd22727; 10: rom_val = 16'd21452; 11: rom_val = 16'd20248;
      12: rom_val = 16'd19111; 13: rom_val = 16'd18039; 14: rom_val = 16'd17026;
      15: rom_val = 16'd16071; 16: rom_val = 16'd15169;
      default: rom_val = 16'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] rom_scaled(input int i);
    rom_scaled = CNT_W'(rom_val(i) >> ROM_SHIFT);
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise, sat, accept;
  logic [CNT_W-1:0] cnt_q, period_q;
  logic             armed_q, pv_q;
  logic             m_ok_d, m_ok_q, mev_q;
  logic [4:0]       m_idx_d, m_idx_q;
  state_t           state_q, state_d;
  logic [4:0]       cand_q, cand_d, idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d, strobe_q, strobe_d;

  assign rise = s2_q & ~s3_q;
  assign sat  = (cnt_q == CNT_MAX);

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= audio_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // An edge while disarmed or during saturation only arms; it never yields a period.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (rise) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
        if (armed_q && !sat) begin
          period_q <= cnt_q + ONE;
          pv_q     <= 1'b1;
        end
      end else if (sat) begin
        armed_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

  // Scan high-to-low so the lowest matching index wins when windows overlap.
  always_comb begin
    logic signed [CNT_W:0] diff;
    m_ok_d  = 1'b0;
    m_idx_d = '0;
    diff    = '0;
    for (int i = 16; i >= 0; i--) begin
      diff = $signed({1'b0, period_q}) - $signed({1'b0, rom_scaled(i)});
      if (diff <= TOL_S && diff >= -TOL_S) begin
        m_ok_d  = 1'b1;
        m_idx_d = 5'(i);
      end
    end
  end

`ifdef NOTE_DECODER_DUTY_CHECK_EN
  logic             fall, duty_ok, duty_ok_q;
  logic [CNT_W-1:0] hcnt_q, high_q, p_cur, p_quarter;

  assign fall      = s3_q & ~s2_q;
  assign p_cur     = cnt_q + ONE;
  assign p_quarter = p_cur >> 2;
  assign duty_ok   = (high_q >= p_quarter) && (high_q <= p_cur - p_quarter);
  assign accept    = m_ok_d & duty_ok_q;

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      hcnt_q    <= '0;
      high_q    <= '0;
      duty_ok_q <= 1'b0;
    end else begin
      if (rise) hcnt_q <= '0;
      else if (hcnt_q != CNT_MAX) hcnt_q <= hcnt_q + ONE;
      if (fall) high_q <= (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + ONE;
      if (rise) duty_ok_q <= duty_ok;
    end
  end
`else
  assign accept = m_ok_d;
`endif

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      mev_q   <= 1'b0;
      m_ok_q  <= 1'b0;
      m_idx_q <= '0;
    end else begin
      mev_q   <= pv_q;
      m_ok_q  <= accept;
      m_idx_q <= m_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    count_d  = count_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    if (sat || (mev_q && !m_ok_q)) begin
      state_d = IDLE;
      count_d = '0;
      valid_d = 1'b0;
    end else if (mev_q) begin
      if (state_q == IDLE || m_idx_q != cand_q) begin
        state_d = TRACK;
        cand_d  = m_idx_q;
        count_d = CNT_ONE;
        valid_d = 1'b0;
      end else if (state_q == TRACK) begin
        count_d = count_q + CNT_ONE;
      end
      if (state_d == TRACK && count_d == STABLE_C) begin
        state_d  = LOCKED;
        idx_d    = cand_d;
        valid_d  = 1'b1;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  assign note_valid  = valid_q;
  assign note_idx    = idx_q;
  assign note_onehot = valid_q ? (17'd1 << idx_q) : 17'd0;
  assign note_strobe = strobe_q;
  assign period_out  = period_q;
endmodule
